// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and execute-side resolve bundle for the branch predictor.
// master = pipeline (drives fetch PC and resolved outcomes), slave = predictor.
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 32,
  parameter int HIST_W = 6,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              pred_hit;
  logic [HIST_W-1:0] pred_hist;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic [HIST_W-1:0] upd_hist;
  logic              upd_mispredict;

  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  mispredict_count;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_hist, upd_mispredict,
    input  pred_taken, pred_target, pred_hit, pred_hist, branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_hist, upd_mispredict,
    output pred_taken, pred_target, pred_hit, pred_hist, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB plus saturating-counter pattern table, bimodal or gshare indexed.
// Lookup is combinational from register state; resolve updates land on the clock edge.
module branch_predictor_btb #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int MODE    = 0,
  parameter int HIST_W  = 6,
  parameter int CNT_W   = 16
) (
  input logic                    clock,
  input logic                    reset,
  branch_predictor_btb_if.slave  bp
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [HIST_W-1:0]  ghr_q;
  logic [CNT_W-1:0]   branch_cnt_q;
  logic [CNT_W-1:0]   mispred_cnt_q;

  function automatic logic [INDEX_W-1:0] ctr_index(input logic [ADDR_W-1:0] pc,
                                                   input logic [HIST_W-1:0] hist);
    if (MODE == 1) return pc[INDEX_W+1:2] ^ INDEX_W'(hist);
    else           return pc[INDEX_W+1:2];
  endfunction

  logic [INDEX_W-1:0] f_idx, f_cidx, u_idx, u_cidx;
  logic [TAG_W-1:0]   f_tag, u_tag;
  logic               f_hit, f_taken;
  logic [CTR_W-1:0]   u_ctr;

  assign f_idx   = bp.fetch_pc[INDEX_W+1:2];
  assign f_tag   = bp.fetch_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign f_cidx  = ctr_index(bp.fetch_pc, ghr_q);
  assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken = f_hit && ctr_q[f_cidx][CTR_W-1];

  assign bp.pred_hit         = f_hit;
  assign bp.pred_taken       = f_taken;
  assign bp.pred_target      = f_taken ? target_q[f_idx] : bp.fetch_pc + ADDR_W'(4);
  assign bp.pred_hist        = ghr_q;
  assign bp.branch_count     = branch_cnt_q;
  assign bp.mispredict_count = mispred_cnt_q;

  assign u_idx  = bp.upd_pc[INDEX_W+1:2];
  assign u_tag  = bp.upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign u_cidx = ctr_index(bp.upd_pc, bp.upd_hist);
  assign u_ctr  = ctr_q[u_cidx];

  // Only the index/tag bits of the resolve PC (and, in bimodal mode, none of the
  // carried history) feed the tables.
  logic unused_upd_bits;
  assign unused_upd_bits = ^{bp.upd_pc, bp.upd_hist};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else if (bp.upd_valid) begin
      if (bp.upd_taken) begin
        if (u_ctr != CTR_MAX) ctr_q[u_cidx] <= u_ctr + CTR_W'(1);
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= bp.upd_target;
      end else if (u_ctr != '0) begin
        ctr_q[u_cidx] <= u_ctr - CTR_W'(1);
      end
      // History is architectural: shifted only when a branch resolves.
      if (MODE == 1) ghr_q <= HIST_W'({ghr_q, bp.upd_taken});
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (bp.upd_mispredict && (mispred_cnt_q != '1))
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end
endmodule
